// File: rtl/pmem_burst_adapter.sv
// rtl/pmem_burst_adapter.sv - 128-bit line to 4x32-bit beat burst adapter (optional PMEM_BURST_TIMEOUT_EN)
module pmem_burst_adapter #(
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [127:0] pmem_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [15:0]  mem_address,
  output logic [31:0]  mem_wdata,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_resp
`ifdef PMEM_BURST_TIMEOUT_EN
  ,
  output logic         pmem_err
`endif
);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

  state_t        state;
  logic [1:0]    beat;
  logic [1:0]    next_beat;
  logic [11:0]   line_addr;
  logic [127:0]  wline_q;
  logic [95:0]   rd_buf;

  // Byte offset within a line has no meaning here; the timeout depth is unused without the timer.
  logic          unused_offset;
  localparam int unused_timeout = TIMEOUT;
  assign unused_offset = ^pmem_address[3:0];

  assign next_beat = beat + 2'd1;

`ifdef PMEM_BURST_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0] wait_cnt;
`endif

  // Burst sequencer: latches the line request, walks beats 0..3, then pulses pmem_resp for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      beat        <= 2'd0;
      line_addr   <= 12'd0;
      wline_q     <= 128'd0;
      rd_buf      <= 96'd0;
      pmem_resp   <= 1'b0;
      pmem_rdata  <= 128'd0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= 16'd0;
      mem_wdata   <= 32'd0;
`ifdef PMEM_BURST_TIMEOUT_EN
      wait_cnt    <= '0;
      pmem_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          beat <= 2'd0;
`ifdef PMEM_BURST_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          // Read has priority when both requests are raised together.
          if (pmem_read) begin
            line_addr   <= pmem_address[15:4];
            mem_address <= {pmem_address[15:4], 4'b0000};
            mem_read    <= 1'b1;
            state       <= RD_BURST;
          end else if (pmem_write) begin
            line_addr   <= pmem_address[15:4];
            wline_q     <= pmem_wdata;
            mem_address <= {pmem_address[15:4], 4'b0000};
            mem_wdata   <= pmem_wdata[31:0];
            mem_write   <= 1'b1;
            state       <= WR_BURST;
          end
        end
        RD_BURST, WR_BURST: begin
          if (mem_resp) begin
`ifdef PMEM_BURST_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            // Read beats gather into a side buffer; the visible line is replaced only when the
            // last beat lands, so an aborted read never leaves a half-updated line behind.
            if (state == RD_BURST) begin
              case (beat)
                2'd0:    rd_buf[31:0]  <= mem_rdata;
                2'd1:    rd_buf[63:32] <= mem_rdata;
                2'd2:    rd_buf[95:64] <= mem_rdata;
                default: pmem_rdata    <= {mem_rdata, rd_buf};
              endcase
            end
            if (beat == 2'd3) begin
              state     <= DONE;
              mem_read  <= 1'b0;
              mem_write <= 1'b0;
              pmem_resp <= 1'b1;
              beat      <= 2'd0;
            end else begin
              beat        <= next_beat;
              mem_address <= {line_addr, next_beat, 2'b00};
              mem_wdata   <= wline_q[{next_beat, 5'b00000} +: 32];
            end
          end
`ifdef PMEM_BURST_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            state     <= DONE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            pmem_resp <= 1'b1;
            pmem_err  <= 1'b1;
            beat      <= 2'd0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
`endif
        end
        DONE: begin
          pmem_resp <= 1'b0;
`ifdef PMEM_BURST_TIMEOUT_EN
          pmem_err  <= 1'b0;
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_burst_adapter.sv
// tb/tb_pmem_burst_adapter.sv - randomized self-checking bench for pmem_burst_adapter
module tb_pmem_burst_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [15:0]  mem_address;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
`ifdef PMEM_BURST_TIMEOUT_EN
  logic         pmem_err;
`endif

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [127:0] last_line;

`ifdef PMEM_BURST_TIMEOUT_EN
  pmem_burst_adapter #(.TIMEOUT(8)) dut (
`else
  pmem_burst_adapter dut (
`endif
    .clk(clk), .rst(rst),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
`ifdef PMEM_BURST_TIMEOUT_EN
    , .pmem_err(pmem_err)
`endif
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One line transaction seen from the cache side. Beat n of the line is expected at
  // {addr[15:4], n, 00} carrying line word n; the returned line is the words we supplied.
  // mode 0: mem_resp tied high, 1: random, 2: every third cycle.
  task automatic run_burst(input bit is_read, input bit both, input logic [15:0] addr,
                           input logic [127:0] wline, input logic [127:0] rline,
                           input int mode, input bit hold_req);
    int  n;
    bit  done;
    bit  resp;
    n    = 0;
    done = 0;
    pmem_read    = is_read;
    pmem_write   = !is_read || both;
    pmem_address = addr;
    pmem_wdata   = wline;
    for (int c = 1; c <= 200 && !done; c++) begin
      @(negedge clk);
      if (pmem_resp) begin
        done = 1;
        check("beat_count", 128'(n), 128'd4);
        check("latency_min", 128'(c >= 5), 128'd1);
        if (is_read) last_line = rline;
        check("line_rdata", pmem_rdata, last_line);
        check("rw_low_at_resp", {mem_read, mem_write}, 2'b00);
`ifdef PMEM_BURST_TIMEOUT_EN
        check("err_clear", pmem_err, 1'b0);
`endif
        if (!hold_req) begin
          pmem_read  = 1'b0;
          pmem_write = 1'b0;
        end
        mem_resp = 1'($urandom);
      end else begin
        check("rd_level", mem_read, is_read);
        check("wr_level", mem_write, !is_read);
        case (mode)
          0:       resp = 1'b1;
          2:       resp = (c % 3) == 0;
          default: resp = 1'($urandom_range(0, 1));
        endcase
        if (resp) begin
          if (n < 4) begin
            check("beat_addr", mem_address, {addr[15:4], n[1:0], 2'b00});
            if (!is_read) check("beat_wdata", mem_wdata, wline[32*n +: 32]);
            mem_rdata = rline[32*n +: 32];
          end
          n++;
        end
        mem_resp     = resp;
        pmem_address = 16'($urandom);
        pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    if (!done) check("burst_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      check("idle_quiet", {pmem_resp, mem_read, mem_write}, 3'b000);
      check("idle_hold_line", pmem_rdata, last_line);
    end
  endtask

  initial begin
    logic [127:0] rl;
    rst = 1'b1; pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0;
    pmem_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    last_line = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {pmem_resp, mem_read, mem_write}, 3'b000);
    check("rst_rdata", pmem_rdata, 128'd0);
    check("rst_addr_wdata", {mem_address, mem_wdata}, 48'd0);
    rst = 1'b0;
    idle_cycles(1);

    // Directed read at 0x1234 with mem_resp tied high.
    run_burst(1, 0, 16'h1234, '0, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0, 0);
    rl = 128'h000000A3_000000A2_000000A1_000000A0;
    check("read_line_0x1234", pmem_rdata, rl);
    idle_cycles(1);

    // Directed write at 0x0040, response every third cycle; read line must survive.
    run_burst(0, 0, 16'h0040, 128'h33333333_22222222_11111111_00000000,
              {$urandom, $urandom, $urandom, $urandom}, 2, 0);
    check("write_keeps_line", pmem_rdata, rl);
    idle_cycles(2);

    // Both requests high: read only.
    run_burst(1, 1, 16'hBEEF, {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, 1, 0);
    idle_cycles(1);

    // Back-to-back: request kept high through DONE restarts right after it.
    run_burst(1, 0, 16'h2000, '0, {$urandom, $urandom, $urandom, $urandom}, 0, 1);
    @(negedge clk);
    check("b2b_idle_gap", {mem_read, pmem_resp}, 2'b00);
    run_burst(1, 0, 16'h3010, '0, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    idle_cycles(1);

    // Randomized transactions.
    for (int t = 0; t < 30; t++) begin
      run_burst(1'($urandom), 1'($urandom), 16'($urandom),
                {$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom},
                int'($urandom_range(0, 2)), 0);
      idle_cycles(int'($urandom_range(1, 3)));
    end

    // Reset after beat 1 of a read aborts with no response.
    pmem_read = 1'b1; pmem_address = 16'h5670; mem_resp = 1'b0;
    @(negedge clk);
    check("rst_mid_reading", mem_read, 1'b1);
    mem_resp = 1'b1; mem_rdata = $urandom;
    @(negedge clk);
    mem_rdata = $urandom;
    @(negedge clk);
    check("rst_mid_beat2_addr", mem_address, 16'h5678);
    rst = 1'b1; pmem_read = 1'b0;
    @(negedge clk);
    check("rst_mid_ctrl", {pmem_resp, mem_read, mem_write}, 3'b000);
    check("rst_mid_rdata", pmem_rdata, 128'd0);
    check("rst_mid_addr_wdata", {mem_address, mem_wdata}, 48'd0);
    rst = 1'b0;
    last_line = '0;
    idle_cycles(4);
    mem_resp = 1'b0;

`ifdef PMEM_BURST_TIMEOUT_EN
    // Timeout: no response at all, abort eight cycles after mem_read rises.
    begin
      int  tc;
      bit  seen;
      seen = 0;
      tc   = 0;
      pmem_read = 1'b1; pmem_address = 16'h0A00; mem_resp = 1'b0;
      for (int c = 1; c <= 50 && !seen; c++) begin
        @(negedge clk);
        if (pmem_resp) begin
          seen = 1;
          tc   = c;
          check("to_err", pmem_err, 1'b1);
          check("to_line_kept", pmem_rdata, last_line);
          pmem_read = 1'b0;
        end
      end
      check("to_seen", 128'(seen), 128'd1);
      check("to_latency", 128'(tc), 128'd9);
      @(negedge clk);
      check("to_back_idle", {pmem_err, pmem_resp, mem_read}, 3'b000);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
